// File: rtl/gen_write_logic_cap_if.sv
// ADC sample input and capture-SRAM write bus for the capture writer.
// master = the writer (consumes ADC lanes, drives bank strobes/address/data).
interface gen_write_logic_cap_if #(
  parameter int NUM_MEM       = 24,
  parameter int LANES_PER_MEM = 4,
  parameter int LANE_W        = 9,
  parameter int ADDR_W        = 15
);
  localparam int DW = NUM_MEM * LANES_PER_MEM * LANE_W;

  logic              adc_trig;
  logic              adc_vld;
  logic [DW-1:0]     adc_din;
  logic [NUM_MEM-1:0] cap_chip_en;
  logic [ADDR_W-1:0] cap_addr;
  logic [DW-1:0]     cap_wdata;

  modport master (input adc_trig, adc_vld, adc_din,
                  output cap_chip_en, cap_addr, cap_wdata);
  modport slave  (output adc_trig, adc_vld, adc_din,
                  input cap_chip_en, cap_addr, cap_wdata);
endinterface

// File: rtl/gen_write_logic_cap.sv
// Capture-memory writer: arm, wait for trigger, write depth+1 words of packed
// ADC lanes into the capture banks, then flag done.
module gen_write_logic_cap_bank #(
  parameter int LANES_PER_MEM = 4,
  parameter int LANE_W        = 9
) (
  input  logic                            wr,
  input  logic                            bank_on,
  input  logic [LANES_PER_MEM*LANE_W-1:0] din,
  input  logic [LANES_PER_MEM*LANE_W-1:0] word_q,
  output logic [LANES_PER_MEM*LANE_W-1:0] word_d
);
  // Lane j of this bank sits at slice j so the read path's sel%4 picks it back out.
  logic [LANES_PER_MEM*LANE_W-1:0] packed_w;
  for (genvar j = 0; j < LANES_PER_MEM; j++) begin : g_lane
    assign packed_w[j*LANE_W +: LANE_W] = bank_on ? din[j*LANE_W +: LANE_W] : '0;
  end
  assign word_d = wr ? packed_w : word_q;
endmodule

module gen_write_logic_cap #(
  parameter int NUM_MEM       = 24,
  parameter int LANES_PER_MEM = 4,
  parameter int LANE_W        = 9,
  parameter int ADDR_W        = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rf_96path_en,
  input  logic              rf_cap_start_pulse,
  input  logic              rf_cap_abort,
  input  logic [ADDR_W-1:0] rf_cap_depth,
  input  logic              mdio_read_en,
  gen_write_logic_cap_if.master cap,
  output logic              cap_busy,
  output logic              cap_done,
  output logic [15:0]       cap_wr_cnt
);
  localparam int BANK_W = LANES_PER_MEM * LANE_W;
  localparam int HALF   = NUM_MEM / 2;

  typedef enum logic [1:0] {IDLE, ARM, WRITE, DONE} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               depth_q, depth_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [NUM_MEM-1:0]              chip_en_q, chip_en_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [NUM_MEM-1:0][BANK_W-1:0]  wdata_q, wdata_d;

  logic start_ok, wr_fire, last;

  assign start_ok = rf_cap_start_pulse && !mdio_read_en && !rf_cap_abort &&
                    (state_q == IDLE || state_q == DONE);
  // The trigger cycle itself may carry word 0.
  assign wr_fire  = !rf_cap_abort && !mdio_read_en && cap.adc_vld &&
                    (state_q == WRITE || (state_q == ARM && cap.adc_trig));
  assign last     = (cnt_q[ADDR_W-1:0] == depth_q);

  always_comb begin
    state_d   = state_q;
    depth_d   = start_ok ? rf_cap_depth : depth_q;
    cnt_d     = start_ok ? 16'd0 : (wr_fire ? cnt_q + 16'd1 : cnt_q);
    addr_d    = wr_fire ? cnt_q[ADDR_W-1:0] : addr_q;
    chip_en_d = '0;
    if (wr_fire)
      chip_en_d = rf_96path_en ? {NUM_MEM{1'b1}} : {{(NUM_MEM-HALF){1'b0}}, {HALF{1'b1}}};
    if (rf_cap_abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE, DONE: if (start_ok) state_d = ARM;
        ARM:        if (cap.adc_trig) state_d = (wr_fire && last) ? DONE : WRITE;
        WRITE:      if (wr_fire && last) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
    busy_d = (state_d == ARM) || (state_d == WRITE);
    // Done shows one cycle after the final write and drops on the way out of DONE.
    done_d = (state_d == DONE) && (state_q == DONE);
  end

  for (genvar i = 0; i < NUM_MEM; i++) begin : g_bank
    gen_write_logic_cap_bank #(.LANES_PER_MEM(LANES_PER_MEM), .LANE_W(LANE_W)) u_bank (
      .wr      (wr_fire),
      .bank_on (rf_96path_en || (i < HALF)),
      .din     (cap.adc_din[i*BANK_W +: BANK_W]),
      .word_q  (wdata_q[i]),
      .word_d  (wdata_d[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      depth_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      chip_en_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      chip_en_q <= chip_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wdata_q   <= wdata_d;
    end
  end

  assign cap.cap_chip_en = chip_en_q;
  assign cap.cap_addr    = addr_q;
  assign cap.cap_wdata   = wdata_q;
  assign cap_busy        = busy_q;
  assign cap_done        = done_q;
  assign cap_wr_cnt      = cnt_q;
endmodule
